// File: rtl/alarm_compare_multi.sv
// Compares running hour/min against N programmable alarm slots, each with edge trigger, pending flag and snooze.
// H, pending, ring and ring_idx are registered: they update one cycle after the matching time is presented.
module alarm_compare_multi #(
    parameter int N_ALARMS   = 4,
    parameter int IDX_W      = 2,
    parameter int ALARM_HOUR = 7,
    parameter int ALARM_MIN  = 30,
    parameter int SNOOZE_MIN = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          hour,
    input  logic [5:0]          min,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [4:0]          wr_hour,
    input  logic [5:0]          wr_min,
    input  logic                wr_enable,
    input  logic                ack,
    input  logic                snooze,
    input  logic [IDX_W-1:0]    cmd_idx,
    output logic                H,
    output logic [N_ALARMS-1:0] pending,
    output logic                ring,
    output logic [IDX_W-1:0]    ring_idx
);
    logic [N_ALARMS-1:0] en, snz_act, match_prev;
    logic [4:0]          a_hour [N_ALARMS];
    logic [5:0]          a_min  [N_ALARMS];
    logic [4:0]          s_hour [N_ALARMS];
    logic [5:0]          s_min  [N_ALARMS];

    logic [N_ALARMS-1:0] snz_hit, match_now, rise, wr_hit, cmd_hit;
    logic [N_ALARMS-1:0] en_nxt, snz_nxt, pend_nxt;
    logic [4:0]          a_hour_nxt [N_ALARMS];
    logic [5:0]          a_min_nxt  [N_ALARMS];
    logic [4:0]          s_hour_nxt [N_ALARMS];
    logic [5:0]          s_min_nxt  [N_ALARMS];
    logic [6:0]          min_sum;
    logic [4:0]          snz_hour;
    logic [5:0]          snz_min;
    logic                wr_ok;
    logic [IDX_W-1:0]    idx_nxt;

    // Out-of-range indices simply never decode to a slot, so those commands fall away.
    assign wr_ok = wr_en && (wr_hour <= 5'd23) && (wr_min <= 6'd59);

    always_comb begin
        min_sum  = {1'b0, min} + 7'(SNOOZE_MIN);
        snz_hour = hour;
        snz_min  = min_sum[5:0];
        if (min_sum >= 7'd60) begin
            snz_min  = 6'(min_sum - 7'd60);
            snz_hour = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
        end
    end

    // Priority per slot: write > rise > ack > snooze.
    always_comb begin
        for (int i = 0; i < N_ALARMS; i++) begin
            snz_hit[i]   = snz_act[i] && (hour == s_hour[i]) && (min == s_min[i]);
            match_now[i] = en[i] && (((hour == a_hour[i]) && (min == a_min[i])) || snz_hit[i]);
            rise[i]      = match_now[i] && !match_prev[i];
            wr_hit[i]    = wr_ok && (wr_idx == IDX_W'(i));
            cmd_hit[i]   = (cmd_idx == IDX_W'(i));

            en_nxt[i]     = en[i];
            snz_nxt[i]    = snz_act[i];
            pend_nxt[i]   = pending[i];
            a_hour_nxt[i] = a_hour[i];
            a_min_nxt[i]  = a_min[i];
            s_hour_nxt[i] = s_hour[i];
            s_min_nxt[i]  = s_min[i];

            if (rise[i]) begin
                pend_nxt[i] = 1'b1;
                if (snz_hit[i]) snz_nxt[i] = 1'b0;
            end else if (ack && cmd_hit[i]) begin
                pend_nxt[i] = 1'b0;
                snz_nxt[i]  = 1'b0;
            end else if (snooze && cmd_hit[i] && pending[i]) begin
                pend_nxt[i]   = 1'b0;
                snz_nxt[i]    = 1'b1;
                s_hour_nxt[i] = snz_hour;
                s_min_nxt[i]  = snz_min;
            end

            if (wr_hit[i]) begin
                en_nxt[i]     = wr_enable;
                a_hour_nxt[i] = wr_hour;
                a_min_nxt[i]  = wr_min;
                pend_nxt[i]   = 1'b0;
                snz_nxt[i]    = 1'b0;
            end
        end
    end

    always_comb begin
        idx_nxt = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (pend_nxt[i]) idx_nxt = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en         <= N_ALARMS'(1);
            snz_act    <= '0;
            match_prev <= '0;
            pending    <= '0;
            H          <= 1'b0;
            ring       <= 1'b0;
            ring_idx   <= '0;
            for (int i = 0; i < N_ALARMS; i++) begin
                a_hour[i] <= (i == 0) ? 5'(ALARM_HOUR) : 5'd0;
                a_min[i]  <= (i == 0) ? 6'(ALARM_MIN) : 6'd0;
                s_hour[i] <= 5'd0;
                s_min[i]  <= 6'd0;
            end
        end else begin
            en         <= en_nxt;
            snz_act    <= snz_nxt;
            match_prev <= match_now;
            pending    <= pend_nxt;
            H          <= |rise;
            ring       <= |pend_nxt;
            ring_idx   <= idx_nxt;
            for (int i = 0; i < N_ALARMS; i++) begin
                a_hour[i] <= a_hour_nxt[i];
                a_min[i]  <= a_min_nxt[i];
                s_hour[i] <= s_hour_nxt[i];
                s_min[i]  <= s_min_nxt[i];
            end
        end
    end
endmodule

// File: tb/tb_alarm_compare_multi.sv
// Bench for alarm_compare_multi: vector table, hand-written corner sequences and random traffic
// checked every cycle against a minutes-of-day reference model.
module tb_alarm_compare_multi;
    localparam int N   = 4;
    localparam int SNZ = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] hour;
    logic [5:0] min;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [4:0] wr_hour;
    logic [5:0] wr_min;
    logic       wr_enable;
    logic       ack;
    logic       snooze;
    logic [1:0] cmd_idx;
    logic       H;
    logic [3:0] pending;
    logic       ring;
    logic [1:0] ring_idx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alarm_compare_multi #(
        .N_ALARMS(N), .IDX_W(2), .ALARM_HOUR(7), .ALARM_MIN(30), .SNOOZE_MIN(SNZ)
    ) dut (
        .clk(clk), .rst(rst), .hour(hour), .min(min),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_hour(wr_hour), .wr_min(wr_min), .wr_enable(wr_enable),
        .ack(ack), .snooze(snooze), .cmd_idx(cmd_idx),
        .H(H), .pending(pending), .ring(ring), .ring_idx(ring_idx)
    );

    // Reference model: times held as minutes since midnight.
    int m_at [N];
    bit m_en [N];
    bit m_sa [N];
    int m_st [N];
    bit m_mp [N];
    bit m_pd [N];
    bit m_H;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_at[i] = (i == 0) ? 7 * 60 + 30 : 0;
            m_en[i] = (i == 0);
            m_sa[i] = 1'b0;
            m_st[i] = 0;
            m_mp[i] = 1'b0;
            m_pd[i] = 1'b0;
        end
        m_H = 1'b0;
    endfunction

    function automatic void model_step();
        int t;
        bit snz_t [N];
        bit hit [N];
        bit fired [N];
        bit any;
        t   = int'(hour) * 60 + int'(min);
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            snz_t[i] = m_sa[i] && (t == m_st[i]);
            hit[i]   = m_en[i] && ((t == m_at[i]) || snz_t[i]);
            fired[i] = hit[i] && !m_mp[i];
            any      = any | fired[i];
        end
        for (int i = 0; i < N; i++) begin
            if (fired[i]) begin
                m_pd[i] = 1'b1;
                if (snz_t[i]) m_sa[i] = 1'b0;
            end else if (ack && int'(cmd_idx) == i) begin
                m_pd[i] = 1'b0;
                m_sa[i] = 1'b0;
            end else if (snooze && int'(cmd_idx) == i && m_pd[i]) begin
                m_pd[i] = 1'b0;
                m_sa[i] = 1'b1;
                m_st[i] = (t + SNZ) % 1440;
            end
            if (wr_en && int'(wr_idx) == i && wr_hour <= 23 && wr_min <= 59) begin
                m_at[i] = int'(wr_hour) * 60 + int'(wr_min);
                m_en[i] = wr_enable;
                m_pd[i] = 1'b0;
                m_sa[i] = 1'b0;
            end
            m_mp[i] = hit[i];
        end
        m_H = any;
    endfunction

    function automatic logic [7:0] model_out();
        logic [3:0] p;
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = N - 1; i >= 0; i--) begin
            p[i] = m_pd[i];
            if (m_pd[i]) idx = 2'(i);
        end
        return {m_H, p, |p, idx};
    endfunction

    task automatic check(input string name, input logic [7:0] want);
        logic [7:0] got;
        got = {H, pending, ring, ring_idx};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t: got H=%b pend=%b ring=%b idx=%0d, want H=%b pend=%b ring=%b idx=%0d",
                     name, $time, got[7], got[6:3], got[2], got[1:0], want[7], want[6:3], want[2], want[1:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("model", model_out());
    endtask

    task automatic drive(input int h, input int m, input bit we, input int wi, input int wh, input int wm,
                         input bit wen, input bit a, input bit s, input int ci);
        hour      = 5'(h);
        min       = 6'(m);
        wr_en     = we;
        wr_idx    = 2'(wi);
        wr_hour   = 5'(wh);
        wr_min    = 6'(wm);
        wr_enable = wen;
        ack       = a;
        snooze    = s;
        cmd_idx   = 2'(ci);
        step();
        wr_en  = 1'b0;
        ack    = 1'b0;
        snooze = 1'b0;
    endtask

    task automatic tick(input int h, input int m);
        drive(h, m, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic tick_wr(input int h, input int m, input int wi, input int wh, input int wm, input bit wen);
        drive(h, m, 1'b1, wi, wh, wm, wen, 1'b0, 1'b0, 0);
    endtask

    task automatic tick_cmd(input int h, input int m, input bit a, input bit s, input int ci);
        drive(h, m, 1'b0, 0, 0, 0, 1'b0, a, s, ci);
    endtask

    typedef struct {
        int h; int m; bit we; int wi; int wh; int wm; bit wen; bit a; bit s; int ci;
        bit eh; logic [3:0] ep; bit er; int ei;
    } vec_t;

    vec_t tbl [9];
    int pool_h [7] = '{7, 7, 23, 0, 7, 7, 12};
    int pool_m [7] = '{30, 35, 57, 2, 28, 33, 0};

    initial begin
        int hc;
        rst = 1'b1; hour = '0; min = '0; wr_en = 1'b0; wr_idx = '0; wr_hour = '0; wr_min = '0;
        wr_enable = 1'b0; ack = 1'b0; snooze = 1'b0; cmd_idx = '0;
        model_reset();
        #12;
        check("reset_state", 8'h00);
        rst = 1'b0;

        //          h  m  we wi wh wm wen a  s  ci  eH ep       er ei
        tbl[0] = '{7, 29, 0, 0, 0, 0, 0, 0, 0, 0,  0, 4'b0000, 0, 0};
        tbl[1] = '{7, 30, 0, 0, 0, 0, 0, 0, 0, 0,  1, 4'b0001, 1, 0};
        tbl[2] = '{7, 30, 0, 0, 0, 0, 0, 0, 0, 0,  0, 4'b0001, 1, 0};
        tbl[3] = '{7, 30, 1, 2, 7, 30, 1, 0, 0, 0, 0, 4'b0001, 1, 0};
        tbl[4] = '{7, 30, 0, 0, 0, 0, 0, 0, 0, 0,  1, 4'b0101, 1, 0};
        tbl[5] = '{7, 30, 0, 0, 0, 0, 0, 1, 0, 0,  0, 4'b0100, 1, 2};
        tbl[6] = '{7, 30, 0, 0, 0, 0, 0, 1, 0, 2,  0, 4'b0000, 0, 0};
        tbl[7] = '{7, 30, 0, 0, 0, 0, 0, 1, 0, 3,  0, 4'b0000, 0, 0};
        tbl[8] = '{7, 31, 0, 0, 0, 0, 0, 0, 1, 1,  0, 4'b0000, 0, 0};
        for (int k = 0; k < 9; k++) begin
            drive(tbl[k].h, tbl[k].m, tbl[k].we, tbl[k].wi, tbl[k].wh, tbl[k].wm,
                  tbl[k].wen, tbl[k].a, tbl[k].s, tbl[k].ci);
            check($sformatf("vec%0d", k), {tbl[k].eh, tbl[k].ep, tbl[k].er, 2'(tbl[k].ei)});
        end

        // Two slots rising together, then a long level match.
        tick(7, 29);
        tick(7, 30);
        check("two_rise", 8'b1_0101_1_00);
        hc = 0;
        for (int k = 0; k < 100; k++) begin
            tick(7, 30);
            if (H) hc++;
        end
        total++;
        if (hc != 0) begin
            bad++;
            $display("FAIL hold_100: got %0d extra H pulses, want 0", hc);
        end
        tick_cmd(7, 30, 1'b1, 1'b0, 0);
        tick_cmd(7, 30, 1'b1, 1'b0, 2);

        // Snooze across midnight.
        tick_wr(23, 56, 1, 23, 57, 1'b1);
        tick(23, 57);
        check("slot1_fire", 8'b1_0010_1_01);
        tick_cmd(23, 57, 1'b0, 1'b1, 1);
        check("snooze_clr", 8'h00);
        tick(23, 58);
        tick(0, 0);
        tick(0, 1);
        tick(0, 2);
        check("snooze_wrap", 8'b1_0010_1_01);
        tick_cmd(0, 3, 1'b1, 1'b0, 1);
        tick(0, 2);
        check("snooze_spent", 8'h00);

        // Invalid writes leave slot 1 at 23:57.
        tick_wr(10, 0, 1, 24, 0, 1'b1);
        tick_wr(10, 0, 1, 11, 60, 1'b1);
        tick(0, 0);
        check("bad_wr_h24", 8'h00);
        tick(11, 0);
        tick(12, 0);
        check("bad_wr_m60", 8'h00);
        tick(23, 56);
        tick(23, 57);
        check("old_time_kept", 8'b1_0010_1_01);

        // Rise + ack same slot; then ack + snooze together.
        tick_cmd(23, 57, 1'b1, 1'b0, 1);
        tick(23, 56);
        tick_cmd(23, 57, 1'b1, 1'b0, 1);
        check("rise_beats_ack", 8'b1_0010_1_01);
        tick_cmd(23, 58, 1'b1, 1'b1, 1);
        check("ack_beats_snz", 8'h00);
        tick(0, 1);
        tick(0, 2);
        check("snz_not_armed", 8'h00);

        // Asynchronous reset while ringing with a snooze armed.
        tick_wr(7, 0, 1, 7, 30, 1'b1);
        tick_wr(7, 0, 2, 7, 28, 1'b1);
        tick(7, 28);
        check("slot2_fire", 8'b1_0100_1_10);
        tick_cmd(7, 28, 1'b0, 1'b1, 2);
        tick(7, 29);
        tick(7, 30);
        check("pre_reset", 8'b1_0011_1_00);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 8'h00);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(7, 29);
        check("post_reset", 8'h00);
        tick(7, 30);
        check("slot0_restored", 8'b1_0001_1_00);
        tick(7, 33);
        check("snz_cleared", 8'b0_0001_1_00);
        tick_cmd(7, 33, 1'b1, 1'b0, 0);

        // Random traffic over a small pool of related times.
        for (int k = 0; k < 3000; k++) begin
            int ti, wk, wh, wm;
            ti = $urandom_range(0, 6);
            wk = $urandom_range(0, 6);
            wh = pool_h[wk];
            wm = pool_m[wk];
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 0) wh = 24;
                else wm = 60;
            end
            drive(pool_h[ti], pool_m[ti], ($urandom_range(0, 9) == 0), $urandom_range(0, 3), wh, wm,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alarm_compare_multi.md
Name: alarm_compare_multi

Overview:
- Multi-channel successor to the single fixed alarm comparator.
- Compares the running clock time (hour/min from the timekeeping counter) against N runtime-programmable alarm slots.
- Each slot has its own edge-detected trigger, latched pending flag, and snooze.
- Feeds the alarm FSM / buzzer driver with a one-cycle trigger pulse, a ring level and the index of the ringing slot.

Parameters:
- N_ALARMS, 4, number of alarm slots (1..8)
- IDX_W, 2, width of slot index ports; must satisfy 2**IDX_W >= N_ALARMS
- ALARM_HOUR, 7, reset hour of slot 0
- ALARM_MIN, 30, reset minute of slot 0
- SNOOZE_MIN, 5, snooze delay in minutes (1..59)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- hour  in  5  current hour, 0..23
- min  in  6  current minute, 0..59
- wr_en  in  1  program slot wr_idx this cycle
- wr_idx  in  IDX_W  slot to program
- wr_hour  in  5  alarm hour to write
- wr_min  in  6  alarm minute to write
- wr_enable  in  1  slot enable to write
- ack  in  1  stop the alarm of slot cmd_idx
- snooze  in  1  snooze the alarm of slot cmd_idx
- cmd_idx  in  IDX_W  target slot for ack/snooze
- H  out  1  one-cycle pulse when any slot newly triggers
- pending  out  N_ALARMS  per-slot latched ring flags
- ring  out  1  OR of pending
- ring_idx  out  IDX_W  lowest-numbered pending slot; 0 when none

Behaviour:
- Reset (asynchronous, immediate):
  - Slot 0 = {ALARM_HOUR, ALARM_MIN, enabled}; other slots = {0, 0, disabled}.
  - All snooze state, match_prev, pending and H cleared; ring = 0, ring_idx = 0.
- Per-slot state: en, a_hour, a_min, snz_act, s_hour, s_min, match_prev, pending.
- match_now[i] = en[i] && ((hour==a_hour[i] && min==a_min[i]) || (snz_act[i] && hour==s_hour[i] && min==s_min[i])). Combinational on registered slot state.
- Every cycle: match_prev[i] <= match_now[i]; rise[i] = match_now[i] & ~match_prev[i].
- Trigger:
  - rise[i] sets pending[i] and clears snz_act[i] when the match came from the snooze time.
  - H <= |rise, registered, so H asserts one cycle after the edge is seen.
  - Several slots rising in the same cycle produce a single H pulse and set all their pending bits.
- pending, ring and ring_idx are registered; they update in the same cycle as H.
- ack with cmd_idx = i: clears pending[i] and snz_act[i]. An ack to an out-of-range or idle slot has no effect.
- snooze with cmd_idx = i and pending[i] = 1:
  - Clears pending[i] and sets snz_act[i].
  - Snooze time = current {hour, min} + SNOOZE_MIN. When the minute sum is >= 60, subtract 60 and increment the hour; hour 23 increments to 0.
  - Snooze to a non-pending slot is ignored.
- ack and snooze in the same cycle: ack wins.
- Same cycle, same slot, rise and ack/snooze: rise wins; pending stays 1 and snooze is not armed.
- Programming:
  - wr_en updates a_hour, a_min and en for slot wr_idx, and clears its pending and snz_act.
  - The write is dropped entirely if wr_hour > 23, wr_min > 59 or wr_idx >= N_ALARMS.
  - New values take effect for comparison from the next cycle.
  - match_prev is not forced, so writing the current time fires one edge on the following cycle.
- Write and ack/snooze to the same slot in the same cycle: write wins.
- Disabling a slot drops its match_now. A still-set pending persists until ack, or until the write itself clears it.
- A level match lasting the whole minute fires exactly once. Re-fire requires match_now to drop and rise again.

Test Plan:
- Reset, then hour=7, min=29→30:
  - H pulses for exactly 1 cycle, one cycle after min=30.
  - pending=0001, ring=1, ring_idx=0.
  - min held at 30 for 100 cycles: no further H.
- Write slot 2 = 07:30 enabled, time 07:30: H once, pending=0101, ring_idx=0. ack cmd_idx=0 → pending=0100, ring_idx=2.
- Slot 1 = 23:57, time 23:57, snooze at 23:57:
  - Snooze time 00:02, snz_act=1, pending[1]=0.
  - Step to 00:02: H pulses, pending[1]=1, snz_act[1]=0.
- Write with wr_hour=24 or wr_min=60: slot contents unchanged, verified by no trigger at the would-be time and a trigger at the old time.
- Simultaneous events:
  - Rise and ack on the same slot and cycle → pending stays 1.
  - ack and snooze on the same cycle → pending cleared, snz_act=0.
- Assert rst mid-ring (pending=0011, snooze armed):
  - Outputs go to 0 without waiting for a clock edge.
  - Slot 0 returns to 07:30 enabled; slot 1 no longer triggers at its old time.
